matmul_sequencer: RTL and testbench
===================================

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: load_en  in  1  write in_data into the element selected by load_sel_ab/load_index.
REQ-004 SHALL have ports: load_sel_ab  in  1  0 selects matrix A, 1 selects matrix B.
REQ-005 SHALL have ports: load_index  in  2  row-major element index ({row,col}).
REQ-006 SHALL have ports: in_data  in  8  signed operand byte.
REQ-007 SHALL have ports: output_en  in  1  request readout of one result byte.
REQ-008 SHALL have ports: output_sel  in  2  result element C[{row,col}].
REQ-009 SHALL have ports: output_hi  in  1  0 selects result bits [7:0], 1 selects bits [15:8].
REQ-010 SHALL have ports: c00, c01, c10, c11  in  16 each  accumulators from the 2x2 PE array.
REQ-011 SHALL have ports: a_row0, a_row1, b_col0, b_col1  out  8 each  skewed operands to the array edges.
REQ-012 SHALL have ports: pe_clear  out  1  zero all PE accumulators; pe_en  out  1  PE advance/accumulate.
REQ-013 SHALL have ports: out_data  out  8  readout byte; busy  out  1  compute in progress; done  out  1  results valid.

Function
REQ-014 SHALL keep an 8-bit load mask (bits 0-3 = A[0..3], 4-7 = B[0..3]) and an 8x8-bit operand store.
REQ-015 SHALL, in IDLE or DONE, on load_en write in_data to the addressed element and set its mask bit; rewriting an element overwrites the data, and the mask bit stays set.
REQ-016 SHALL, on a load_en in DONE, clear the mask and done, write the element, set only its bit, and return to IDLE.
REQ-017 SHALL ignore load_en while busy=1: no data, mask or state change.
REQ-018 SHALL implement states IDLE, CLEAR, FEED0, FEED1, FEED2, FLUSH, CAPTURE, DONE.
REQ-019 SHALL, in IDLE, move to CLEAR on the edge at which the mask becomes 8'hFF (including the edge that writes the eighth element); the mask then resets to 0.
REQ-020 SHALL advance CLEAR->FEED0->FEED1->FEED2->FLUSH->CAPTURE->DONE, one state per cycle, unconditionally.
REQ-021 SHALL drive pe_clear=1 only in CLEAR, and pe_en=1 only in FEED0-FEED2 and FLUSH.
REQ-022 SHALL drive the edges registered-free from state: FEED0 a_row0=A00, a_row1=0, b_col0=B00, b_col1=0; FEED1 A01, A10, B10, B01; FEED2 0, A11, 0, B11; all other states all zero.
REQ-023 SHALL, in CAPTURE, latch c00..c11 into four 16-bit result registers; results hold until the next CAPTURE or reset.
REQ-024 SHALL assert busy=1 in CLEAR through CAPTURE, and done=1 only in DONE.
REQ-025 SHALL, for output_en=1 sampled in DONE, load out_data at that edge with the selected byte of the selected result (1-cycle latency).
REQ-026 SHALL load out_data=0 for output_en=1 in any state other than DONE, and hold out_data when output_en=0.
REQ-027 SHALL honour output_en in the same cycle as a load_en that leaves DONE; the readout uses results from before that edge.
REQ-028 SHALL have a fixed latency of 6 cycles from the completing load edge to done=1.
REQ-029 SHALL perform no arithmetic; operand sign and the 16-bit result format are owned by the PE array.

Reset
REQ-030 SHALL, on rst_n=0 at any time (including mid-compute), asynchronously return to IDLE and clear the mask, the operand store, the result registers and out_data.
REQ-031 SHALL hold busy, done, pe_clear and pe_en at 0 during reset, and drive all edge operands to 0.
REQ-032 SHALL start from an empty mask after reset, so a full 8-element load is required before compute.

Verification
REQ-033 SHALL be verified by: load A={1,2,3,4}, B={5,6,7,8} -> pe_clear 1 cycle; FEED0-2 show a_row0 1,2,0; a_row1 0,3,4; b_col0 5,7,0; b_col1 0,6,8; done 6 cycles after the last load.
REQ-034 SHALL be verified by: drive c00..c11=19,22,43,50 at CAPTURE, then output_sel=3, output_hi=0 -> out_data=50 next cycle; output_hi=1 -> 0.
REQ-035 SHALL be verified by: c01=16'hFFF6 -> readout sel=1, hi=1 gives 8'hFF; hi=0 gives 8'hF6.
REQ-036 SHALL be verified by: load 7 elements, rewrite A00 twice -> no CLEAR; the eighth load starts CLEAR and A00 carries the last value written.
REQ-037 SHALL be verified by: load_en pulses during FEED1 -> operands, mask and timing unchanged; output_en before done -> out_data=0.
REQ-038 SHALL be verified by: rst_n low during FEED2 -> immediate IDLE with pe_en=0, busy=0 and out_data=0; a full reload then yields correct sequencing.

Source files
------------

// File: rtl/matmul_sequencer_if.sv
// Handshake and data bundle between the matmul sequencer, its load/readout
// master and the 2x2 PE array.
interface matmul_sequencer_if;
  localparam int unsigned DW = 8;
  localparam int unsigned RW = 16;

  logic          load_en;
  logic          load_sel_ab;
  logic [1:0]    load_index;
  logic [DW-1:0] in_data;
  logic          output_en;
  logic [1:0]    output_sel;
  logic          output_hi;
  logic [RW-1:0] c00, c01, c10, c11;
  logic [DW-1:0] a_row0, a_row1, b_col0, b_col1;
  logic          pe_clear;
  logic          pe_en;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;

  modport master (
    output load_en, load_sel_ab, load_index, in_data,
    output output_en, output_sel, output_hi,
    output c00, c01, c10, c11,
    input  a_row0, a_row1, b_col0, b_col1,
    input  pe_clear, pe_en, out_data, busy, done
  );

  modport slave (
    input  load_en, load_sel_ab, load_index, in_data,
    input  output_en, output_sel, output_hi,
    input  c00, c01, c10, c11,
    output a_row0, a_row1, b_col0, b_col1,
    output pe_clear, pe_en, out_data, busy, done
  );
endinterface

// File: rtl/matmul_sequencer.sv
// Operand loader and skew sequencer for a 2x2 output-stationary PE array:
// collects A and B, feeds skewed edges, captures and reads back C.
module matmul_sequencer (
  input  logic               clk,
  input  logic               rst_n,
  matmul_sequencer_if.slave  bus
);
  localparam int unsigned DW   = 8;
  localparam int unsigned RW   = 16;
  localparam int unsigned NOPS = 8;
  localparam int unsigned NRES = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED0, S_FEED1, S_FEED2, S_FLUSH, S_CAPTURE, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [NOPS-1:0] mask_q, mask_d;
  logic [DW-1:0]   ops_q [NOPS];
  logic [DW-1:0]   ops_d [NOPS];
  logic [RW-1:0]   res_q [NRES];
  logic [RW-1:0]   res_d [NRES];
  logic [DW-1:0]   out_q, out_d;

  logic [2:0]      load_addr;
  logic [NOPS-1:0] load_bit;
  logic [RW-1:0]   rd_word;

  // Store layout: 0-3 = A00,A01,A10,A11; 4-7 = B00,B01,B10,B11
  assign load_addr = {bus.load_sel_ab, bus.load_index};
  assign load_bit  = NOPS'(1) << load_addr;
  assign rd_word   = res_q[bus.output_sel];
  assign bus.out_data = out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      out_q   <= '0;
      for (int i = 0; i < NOPS; i++) ops_q[i] <= '0;
      for (int i = 0; i < NRES; i++) res_q[i] <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      out_q   <= out_d;
      for (int i = 0; i < NOPS; i++) ops_q[i] <= ops_d[i];
      for (int i = 0; i < NRES; i++) res_q[i] <= res_d[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    ops_d        = ops_q;
    res_d        = res_q;
    out_d        = out_q;
    bus.pe_clear = 1'b0;
    bus.pe_en    = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.a_row0   = '0;
    bus.a_row1   = '0;
    bus.b_col0   = '0;
    bus.b_col1   = '0;

    // Readout samples results as they stood before this edge
    if (bus.output_en) begin
      if (state_q == S_DONE) out_d = bus.output_hi ? rd_word[RW-1:DW] : rd_word[DW-1:0];
      else                   out_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.load_en) begin
          ops_d[load_addr] = bus.in_data;
          if ((mask_q | load_bit) == '1) begin
            mask_d  = '0;
            state_d = S_CLEAR;
          end else begin
            mask_d = mask_q | load_bit;
          end
        end
      end
      S_CLEAR: begin
        bus.pe_clear = 1'b1;
        bus.busy     = 1'b1;
        state_d      = S_FEED0;
      end
      S_FEED0: begin
        bus.pe_en  = 1'b1;
        bus.busy   = 1'b1;
        bus.a_row0 = ops_q[0];
        bus.b_col0 = ops_q[4];
        state_d    = S_FEED1;
      end
      S_FEED1: begin
        bus.pe_en  = 1'b1;
        bus.busy   = 1'b1;
        bus.a_row0 = ops_q[1];
        bus.a_row1 = ops_q[2];
        bus.b_col0 = ops_q[6];
        bus.b_col1 = ops_q[5];
        state_d    = S_FEED2;
      end
      S_FEED2: begin
        bus.pe_en  = 1'b1;
        bus.busy   = 1'b1;
        bus.a_row1 = ops_q[3];
        bus.b_col1 = ops_q[7];
        state_d    = S_FLUSH;
      end
      S_FLUSH: begin
        bus.pe_en = 1'b1;
        bus.busy  = 1'b1;
        state_d   = S_CAPTURE;
      end
      S_CAPTURE: begin
        bus.busy = 1'b1;
        res_d[0] = bus.c00;
        res_d[1] = bus.c01;
        res_d[2] = bus.c10;
        res_d[3] = bus.c11;
        state_d  = S_DONE;
      end
      S_DONE: begin
        bus.done = 1'b1;
        // A new load restarts collection from an empty mask
        if (bus.load_en) begin
          ops_d[load_addr] = bus.in_data;
          mask_d           = load_bit;
          state_d          = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed and randomized checks of matmul_sequencer against a
// cycle-count based reference model of load/compute/readout behaviour.
module tb_matmul_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matmul_sequencer_if bus ();
  matmul_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Model: phase 0 = collecting, 1..6 = cycles since the completing load, 7 = results ready
  int         m_phase;
  logic [7:0] m_mask;
  logic [7:0] mA [4];
  logic [7:0] mB [4];
  logic [15:0] m_res [4];
  logic [7:0] m_out;

  // Systolic skew: at feed step t, row i receives A[i][t-i], column j receives B[t-j][j]
  function automatic logic [7:0] exp_a(int row);
    int t = m_phase - 2;
    int k = t - row;
    if (t < 0 || t > 2 || k < 0 || k > 1) return 8'h00;
    return mA[row*2 + k];
  endfunction

  function automatic logic [7:0] exp_b(int col);
    int t = m_phase - 2;
    int k = t - col;
    if (t < 0 || t > 2 || k < 0 || k > 1) return 8'h00;
    return mB[k*2 + col];
  endfunction

  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      m_phase = 0; m_mask = '0; m_out = '0;
      for (int i = 0; i < 4; i++) begin mA[i] = '0; mB[i] = '0; m_res[i] = '0; end
    end else begin
      if (bus.output_en)
        m_out = (m_phase == 7) ? (bus.output_hi ? m_res[bus.output_sel][15:8] : m_res[bus.output_sel][7:0]) : 8'h00;
      if (m_phase == 6) begin m_res[0] = bus.c00; m_res[1] = bus.c01; m_res[2] = bus.c10; m_res[3] = bus.c11; end
      if (bus.load_en && (m_phase == 0 || m_phase == 7)) begin
        if (m_phase == 7) begin m_mask = '0; m_phase = 0; end
        if (bus.load_sel_ab) mB[bus.load_index] = bus.in_data;
        else                 mA[bus.load_index] = bus.in_data;
        m_mask[{bus.load_sel_ab, bus.load_index}] = 1'b1;
        if (m_mask == 8'hFF) begin m_mask = '0; m_phase = 1; end
      end else if (m_phase >= 1 && m_phase <= 6) begin
        m_phase++;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.load_en = 0; bus.load_sel_ab = 0; bus.load_index = 0; bus.in_data = 0;
    bus.output_en = 0; bus.output_sel = 0; bus.output_hi = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    step(); step();
    rst_n = 1;
  endtask

  task automatic load_one(input logic sel, input logic [1:0] idx, input logic [7:0] d);
    bus.load_en = 1; bus.load_sel_ab = sel; bus.load_index = idx; bus.in_data = d;
    step();
    bus.load_en = 0;
  endtask

  // a/b packed little-endian: byte i = element i in row-major order
  task automatic load_set(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 4; i++) load_one(1'b0, 2'(i), a[8*i +: 8]);
    for (int i = 0; i < 4; i++) load_one(1'b1, 2'(i), b[8*i +: 8]);
  endtask

  task automatic set_c(input logic [15:0] v0, v1, v2, v3);
    bus.c00 = v0; bus.c01 = v1; bus.c10 = v2; bus.c11 = v3;
  endtask

  task automatic test_reset();
    idle_inputs();
    set_c(16'h0, 16'h0, 16'h0, 16'h0);
    rst_n = 0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL reset_flags: busy=%b done=%b expected 0 0", bus.busy, bus.done); end
    checks++; if (bus.pe_clear !== 1'b0 || bus.pe_en !== 1'b0) begin errors++; $display("FAIL reset_pe: clear=%b en=%b expected 0 0", bus.pe_clear, bus.pe_en); end
    do_reset();
    checks++; if ({bus.a_row0, bus.a_row1, bus.b_col0, bus.b_col1} !== 32'h0) begin errors++; $display("FAIL reset_edges: got %h expected 0", {bus.a_row0, bus.a_row1, bus.b_col0, bus.b_col1}); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out: got %h expected 00", bus.out_data); end
  endtask

  task automatic test_basic();
    do_reset();
    set_c(16'd19, 16'd22, 16'd43, 16'd50);
    load_set(32'h04030201, 32'h08070605);
    checks++; if (bus.pe_clear !== 1'b1 || bus.busy !== 1'b1 || bus.pe_en !== 1'b0) begin errors++; $display("FAIL basic_clear: clr=%b busy=%b en=%b expected 1 1 0", bus.pe_clear, bus.busy, bus.pe_en); end
    step();
    checks++; if ({bus.a_row0, bus.a_row1, bus.b_col0, bus.b_col1} !== 32'h01000500 || bus.pe_en !== 1'b1) begin errors++; $display("FAIL basic_feed0: got %h en=%b expected 01000500 1", {bus.a_row0, bus.a_row1, bus.b_col0, bus.b_col1}, bus.pe_en); end
    step();
    checks++; if ({bus.a_row0, bus.a_row1, bus.b_col0, bus.b_col1} !== 32'h02030706) begin errors++; $display("FAIL basic_feed1: got %h expected 02030706", {bus.a_row0, bus.a_row1, bus.b_col0, bus.b_col1}); end
    step();
    checks++; if ({bus.a_row0, bus.a_row1, bus.b_col0, bus.b_col1} !== 32'h00040008) begin errors++; $display("FAIL basic_feed2: got %h expected 00040008", {bus.a_row0, bus.a_row1, bus.b_col0, bus.b_col1}); end
    step();
    checks++; if (bus.pe_en !== 1'b1 || {bus.a_row0, bus.a_row1, bus.b_col0, bus.b_col1} !== 32'h0) begin errors++; $display("FAIL basic_flush: en=%b edges=%h expected 1 0", bus.pe_en, {bus.a_row0, bus.a_row1, bus.b_col0, bus.b_col1}); end
    step();
    checks++; if (bus.pe_en !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL basic_capture: en=%b busy=%b done=%b expected 0 1 0", bus.pe_en, bus.busy, bus.done); end
    step();
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL basic_done_latency: done=%b busy=%b expected 1 0", bus.done, bus.busy); end
    bus.output_en = 1; bus.output_sel = 3; bus.output_hi = 0; step();
    checks++; if (bus.out_data !== 8'd50) begin errors++; $display("FAIL read_c11_lo: got %0d expected 50", bus.out_data); end
    bus.output_hi = 1; step();
    checks++; if (bus.out_data !== 8'd0) begin errors++; $display("FAIL read_c11_hi: got %0d expected 0", bus.out_data); end
    bus.output_sel = 0; bus.output_hi = 0; step();
    checks++; if (bus.out_data !== 8'd19) begin errors++; $display("FAIL read_c00_lo: got %0d expected 19", bus.out_data); end
    bus.output_en = 0; bus.output_sel = 2; step();
    checks++; if (bus.out_data !== 8'd19) begin errors++; $display("FAIL read_hold: got %0d expected 19", bus.out_data); end
  endtask

  task automatic test_signed_readout();
    set_c(16'h1111, 16'hFFF6, 16'h3333, 16'h4444);
    load_set($urandom, $urandom);
    repeat (6) step();
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL signed_done: got %b expected 1", bus.done); end
    bus.output_en = 1; bus.output_sel = 1; bus.output_hi = 1; step();
    checks++; if (bus.out_data !== 8'hFF) begin errors++; $display("FAIL signed_hi: got %h expected ff", bus.out_data); end
    bus.output_hi = 0; step();
    checks++; if (bus.out_data !== 8'hF6) begin errors++; $display("FAIL signed_lo: got %h expected f6", bus.out_data); end
    // Readout coinciding with the load that leaves the results state
    bus.output_hi = 1; bus.load_en = 1; bus.load_sel_ab = 0; bus.load_index = 0; bus.in_data = 8'h5A;
    step();
    idle_inputs();
    checks++; if (bus.out_data !== 8'hFF || bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL load_with_read: out=%h done=%b busy=%b expected ff 0 0", bus.out_data, bus.done, bus.busy); end
  endtask

  task automatic test_rewrite();
    do_reset();
    load_one(0, 0, 8'd9);
    for (int i = 1; i < 7; i++) load_one(i[2], 2'(i), 8'(i + 20));
    load_one(0, 0, 8'd10);
    checks++; if (bus.busy !== 1'b0 || bus.pe_clear !== 1'b0) begin errors++; $display("FAIL rewrite_first: busy=%b clr=%b expected 0 0", bus.busy, bus.pe_clear); end
    load_one(0, 0, 8'd11);
    checks++; if (bus.busy !== 1'b0 || bus.pe_clear !== 1'b0) begin errors++; $display("FAIL rewrite_second: busy=%b clr=%b expected 0 0", bus.busy, bus.pe_clear); end
    load_one(1, 3, 8'd99);
    checks++; if (bus.pe_clear !== 1'b1) begin errors++; $display("FAIL rewrite_eighth: clr=%b expected 1", bus.pe_clear); end
    step();
    checks++; if (bus.a_row0 !== 8'd11 || bus.b_col0 !== 8'd24) begin errors++; $display("FAIL rewrite_value: a_row0=%0d b_col0=%0d expected 11 24", bus.a_row0, bus.b_col0); end
  endtask

  task automatic test_busy_ignore();
    do_reset();
    load_set(32'h04030201, 32'h08070605);
    step(); step();
    bus.load_en = 1; bus.load_sel_ab = 0; bus.load_index = 3; bus.in_data = 8'h77; bus.output_en = 1;
    checks++; if (bus.a_row1 !== 8'd3 || bus.b_col1 !== 8'd6) begin errors++; $display("FAIL busy_feed1: a_row1=%0d b_col1=%0d expected 3 6", bus.a_row1, bus.b_col1); end
    step();
    bus.load_sel_ab = 1; bus.load_index = 3; bus.in_data = 8'h66;
    checks++; if (bus.a_row1 !== 8'd4 || bus.b_col1 !== 8'd8) begin errors++; $display("FAIL busy_feed2: a_row1=%0d b_col1=%0d expected 4 8", bus.a_row1, bus.b_col1); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL busy_readout: got %h expected 00", bus.out_data); end
    step();
    idle_inputs();
    step(); step();
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL busy_timing: done=%b expected 1", bus.done); end
  endtask

  task automatic test_reset_midcompute();
    do_reset();
    set_c(16'h1234, 16'h0, 16'h0, 16'h0);
    load_set($urandom, $urandom);
    repeat (6) step();
    bus.output_en = 1; bus.output_sel = 0; bus.output_hi = 0; step();
    bus.output_en = 0;
    checks++; if (bus.out_data !== 8'h34) begin errors++; $display("FAIL midrst_pre_read: got %h expected 34", bus.out_data); end
    load_set(32'h04030201, 32'h08070605);
    step(); step(); step();
    #2 rst_n = 0;
    #1;
    checks++; if (bus.pe_en !== 1'b0 || bus.busy !== 1'b0 || bus.out_data !== 8'h00 || bus.a_row1 !== 8'h00) begin errors++; $display("FAIL midrst_async: en=%b busy=%b out=%h a_row1=%h expected 0 0 00 00", bus.pe_en, bus.busy, bus.out_data, bus.a_row1); end
    step();
    rst_n = 1;
    load_set(32'h281E140A, 32'h50463C32);
    checks++; if (bus.pe_clear !== 1'b1) begin errors++; $display("FAIL midrst_reload_clear: got %b expected 1", bus.pe_clear); end
    step();
    checks++; if (bus.a_row0 !== 8'd10 || bus.b_col0 !== 8'd50) begin errors++; $display("FAIL midrst_reload_feed0: a_row0=%0d b_col0=%0d expected 10 50", bus.a_row0, bus.b_col0); end
    repeat (5) step();
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL midrst_reload_done: got %b expected 1", bus.done); end
  endtask

  task automatic test_random();
    int dones = 0;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      bus.load_en     = ($urandom_range(0, 2) != 0);
      bus.load_sel_ab = 1'($urandom);
      bus.load_index  = 2'($urandom);
      bus.in_data     = 8'($urandom);
      bus.output_en   = 1'($urandom);
      bus.output_sel  = 2'($urandom);
      bus.output_hi   = 1'($urandom);
      set_c(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      step();
      if (m_phase == 7) dones++;
      checks++; if ({bus.pe_clear, bus.pe_en, bus.busy, bus.done} !== {m_phase == 1, m_phase >= 2 && m_phase <= 5, m_phase >= 1 && m_phase <= 6, m_phase == 7}) begin errors++; $display("FAIL rand_ctrl cyc %0d: got %b expected phase %0d", n, {bus.pe_clear, bus.pe_en, bus.busy, bus.done}, m_phase); end
      checks++; if ({bus.a_row0, bus.a_row1, bus.b_col0, bus.b_col1} !== {exp_a(0), exp_a(1), exp_b(0), exp_b(1)}) begin errors++; $display("FAIL rand_edges cyc %0d: got %h expected %h", n, {bus.a_row0, bus.a_row1, bus.b_col0, bus.b_col1}, {exp_a(0), exp_a(1), exp_b(0), exp_b(1)}); end
      checks++; if (bus.out_data !== m_out) begin errors++; $display("FAIL rand_out cyc %0d: got %h expected %h", n, bus.out_data, m_out); end
    end
    idle_inputs();
    checks++; if (dones == 0) begin errors++; $display("FAIL rand_progress: no compute reached results state"); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed_readout();
    test_rewrite();
    test_busy_ignore();
    test_reset_midcompute();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
